// File: rtl/smooth_dma.sv
// smooth_dma: memory-to-memory block / sliding window averager
// over a single-port synchronous RAM.
module smooth_dma #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int WIN    = 4,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] len,
  input  logic [ADDR_W-1:0] dest,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] out_count,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LW = $clog2(WIN);
  localparam int SW = DATA_W + LW;
  localparam int CW = ADDR_W + 1;
  localparam logic [SW-1:0] RND =
    (ROUND != 0) ? SW'(WIN / 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic              mode_q;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dest_q;
  logic [ADDR_W-1:0] nout_q;
  logic [ADDR_W-1:0] k_q;
  logic [CW-1:0]     i_q;
  logic [SW-1:0]     sum_q;
  logic [DATA_W-1:0] win_q [WIN];

  logic [ADDR_W-1:0] nout_new;
  logic [LW-1:0]     slot;
  logic [SW-1:0]     evict;
  logic [SW-1:0]     sum_cap;
  logic [SW-1:0]     rsum;
  logic [DATA_W-1:0] result;
  logic              win_done;
  logic              last_wr;

  // Output count implied by the request inputs
  always_comb begin
    nout_new = '0;
    if (!mode) begin
      nout_new = len >> LW;
    end else if (len >= ADDR_W'(WIN)) begin
      nout_new = len - ADDR_W'(WIN - 1);
    end
  end

  // Window arithmetic and step conditions
  always_comb begin
    slot     = i_q[LW-1:0];
    evict    = mode_q ? SW'(win_q[slot]) : '0;
    sum_cap  = sum_q + SW'(mem_rdata) - evict;
    rsum     = sum_q + RND;
    result   = rsum[SW-1:LW];
    win_done = mode_q ? ((i_q + 1'b1) >= CW'(WIN))
                      : (slot == LW'(WIN - 1));
    last_wr  = (k_q + 1'b1) == nout_q;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = (nout_new == '0) ? S_FIN : S_RD;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: state_d = win_done ? S_WR : S_RD;
      S_WR:  state_d = last_wr ? S_FIN : S_RD;
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    out_count = nout_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state_q)
      S_RD: begin
        busy     = 1'b1;
        mem_en   = 1'b1;
        mem_addr = src_q + i_q[ADDR_W-1:0];
      end
      S_CAP: busy = 1'b1;
      S_WR: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dest_q + k_q;
        mem_wdata = result;
      end
      S_FIN: begin
        done = 1'b1;
        err  = (nout_q == '0);
      end
      default: ;
    endcase
  end

  // Request latch, sample buffer, running sum and counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      src_q  <= '0;
      dest_q <= '0;
      nout_q <= '0;
      k_q    <= '0;
      i_q    <= '0;
      sum_q  <= '0;
      for (int j = 0; j < WIN; j++) win_q[j] <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode;
            src_q  <= src;
            dest_q <= dest;
            nout_q <= nout_new;
            k_q    <= '0;
            i_q    <= '0;
            sum_q  <= '0;
            for (int j = 0; j < WIN; j++) win_q[j] <= '0;
          end
        end
        S_CAP: begin
          win_q[slot] <= mem_rdata;
          sum_q       <= sum_cap;
          i_q         <= i_q + 1'b1;
        end
        S_WR: begin
          k_q <= k_q + 1'b1;
          if (!mode_q) sum_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_smooth_dma.sv
// tb_smooth_dma: two engines (truncate / round) on private RAMs,
// checked against a window-average model of the request.
module tb_smooth_dma;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start1;
  logic       mode;
  logic [7:0] src, len, dest;

  logic       busy0, done0, err0, en0, we0;
  logic [7:0] oc0, addr0, wd0, rd0;
  logic       busy1, done1, err1, en1, we1;
  logic [7:0] oc1, addr1, wd1, rd1;

  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];
  logic       pl_we;
  logic [7:0] pl_addr, pl_data;
  int         wcnt0 = 0;

  int nvec = 0;
  int nerr = 0;

  bit sel   = 1'b0;
  bit armed = 1'b0;
  bit fin   = 1'b0;
  bit prev_done = 1'b0;
  int cnt, bcnt;
  int exp_busy, exp_nout, exp_err;
  int rdq[$];
  int wqa[$];
  int wqd[$];

  always #5 clk = ~clk;

  smooth_dma #(.DATA_W(8), .ADDR_W(8), .WIN(4), .ROUND(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode),
    .src(src), .len(len), .dest(dest), .busy(busy0),
    .done(done0), .err(err0), .out_count(oc0),
    .mem_en(en0), .mem_we(we0), .mem_addr(addr0),
    .mem_wdata(wd0), .mem_rdata(rd0)
  );

  smooth_dma #(.DATA_W(8), .ADDR_W(8), .WIN(4), .ROUND(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode),
    .src(src), .len(len), .dest(dest), .busy(busy1),
    .done(done1), .err(err1), .out_count(oc1),
    .mem_en(en1), .mem_we(we1), .mem_addr(addr1),
    .mem_wdata(wd1), .mem_rdata(rd1)
  );

  always @(posedge clk) begin
    if (pl_we) begin
      ram0[pl_addr] <= pl_data;
      ram1[pl_addr] <= pl_data;
    end
    if (en0) begin
      if (we0) begin
        ram0[addr0] <= wd0;
        wcnt0 <= wcnt0 + 1;
      end else begin
        rd0 <= ram0[addr0];
      end
    end
    if (en1) begin
      if (we1) ram1[addr1] <= wd1;
      else     rd1 <= ram1[addr1];
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  logic       c_en, c_we, c_busy, c_done, c_err;
  logic [7:0] c_addr, c_wd, c_oc;
  assign c_en   = sel ? en1   : en0;
  assign c_we   = sel ? we1   : we0;
  assign c_busy = sel ? busy1 : busy0;
  assign c_done = sel ? done1 : done0;
  assign c_err  = sel ? err1  : err0;
  assign c_addr = sel ? addr1 : addr0;
  assign c_wd   = sel ? wd1   : wd0;
  assign c_oc   = sel ? oc1   : oc0;

  always @(negedge clk) begin
    if (prev_done) chk("done_pulse", int'(c_done), 0);
    prev_done = c_done;
    if (armed) begin
      cnt++;
      if (c_busy) bcnt++;
      if (c_en && c_we) begin
        chk("wr_expected", int'(wqa.size() > 0), 1);
        if (wqa.size() > 0) begin
          chk("wr_addr", int'(c_addr), wqa.pop_front());
          chk("wr_data", int'(c_wd), wqd.pop_front());
        end
      end else if (c_en) begin
        chk("rd_expected", int'(rdq.size() > 0), 1);
        if (rdq.size() > 0)
          chk("rd_addr", int'(c_addr), rdq.pop_front());
      end
      if (c_done) begin
        chk("busy_at_done", int'(c_busy), 0);
        chk("busy_cycles", bcnt, exp_busy);
        chk("done_latency", cnt, exp_busy + 2);
        chk("out_count", int'(c_oc), exp_nout);
        chk("err", int'(c_err), exp_err);
        chk("reads_left", rdq.size(), 0);
        chk("writes_left", wqa.size(), 0);
        armed = 1'b0;
        fin   = 1'b1;
      end
    end
  end

  task automatic launch(input bit s, input int m, input int a,
                        input int l, input int d, input bit arm);
    int x [256];
    int nout, nrd, base, acc, rnd;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++)
      x[i] = s ? int'(ram1[i]) : int'(ram0[i]);
    rnd = s ? 2 : 0;
    if (m == 0) begin
      nout = l / 4;
      nrd  = nout * 4;
    end else begin
      nout = (l >= 4) ? l - 3 : 0;
      nrd  = (nout > 0) ? l : 0;
    end
    rdq.delete(); wqa.delete(); wqd.delete();
    for (int i = 0; i < nrd; i++) rdq.push_back((a + i) % 256);
    for (int k = 0; k < nout; k++) begin
      base = (m == 0) ? 4 * k : k;
      acc  = 0;
      for (int j = 0; j < 4; j++) acc += x[(a + base + j) % 256];
      wqa.push_back((d + k) % 256);
      wqd.push_back((acc + rnd) / 4);
    end
    exp_busy = 2 * nrd + nout;
    exp_nout = nout;
    exp_err  = (nout == 0) ? 1 : 0;
    sel  = s;
    fin  = 1'b0;
    cnt  = 0;
    bcnt = 0;
    armed = arm;
    mode = m[0];
    src  = a[7:0];
    len  = l[7:0];
    dest = d[7:0];
    if (s) start1 = 1'b1;
    else   start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!fin && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("finished_in_time", int'(fin), 1);
    armed = 1'b0;
  endtask

  task automatic poke(input int a, input int d);
    @(posedge clk); #1;
    pl_we   = 1'b1;
    pl_addr = a[7:0];
    pl_data = d[7:0];
  endtask

  initial begin
    int w, t;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0;
    mode = 1'b0; src = '0; len = '0; dest = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_err", int'(err0), 0);
    chk("rst_en", int'(en0), 0);
    chk("rst_we", int'(we0), 0);
    chk("rst_addr", int'(addr0), 0);
    chk("rst_wdata", int'(wd0), 0);
    chk("rst_oc", int'(oc0), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_en1", int'(en1), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) poke(16'h10 + i, i);
    for (int i = 0; i < 6; i++)  poke(16'h20 + i, i);
    poke('hFE, 255); poke('hFF, 255);
    poke('h00, 255); poke('h01, 255);
    @(posedge clk); #1;
    pl_we = 1'b0;

    launch(0, 0, 'h10, 8, 'h40, 1); wait_done();
    chk("blk_r40", int'(ram0['h40]), 1);
    chk("blk_r41", int'(ram0['h41]), 5);

    launch(1, 0, 'h10, 8, 'h40, 1); wait_done();
    chk("rnd_r40", int'(ram1['h40]), 2);
    chk("rnd_r41", int'(ram1['h41]), 6);

    launch(0, 0, 'h10, 10, 'h48, 1); wait_done();
    chk("len10_r48", int'(ram0['h48]), 1);
    chk("len10_r49", int'(ram0['h49]), 5);

    launch(0, 1, 'h20, 6, 'h50, 1); wait_done();
    chk("sld_r50", int'(ram0['h50]), 1);
    chk("sld_r51", int'(ram0['h51]), 2);
    chk("sld_r52", int'(ram0['h52]), 3);

    launch(0, 1, 'h20, 3, 'h58, 1); wait_done();
    launch(0, 1, 'h20, 0, 'h58, 1); wait_done();
    launch(0, 0, 'h20, 0, 'h58, 1); wait_done();

    launch(0, 0, 'hFE, 4, 'hFE, 1); wait_done();
    chk("wrap_rFE", int'(ram0['hFE]), 255);

    launch(0, 0, 'h10, 8, 'h60, 0);
    t = 0;
    while (!we0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("abort_wr_seen", int'(we0), 1);
    rst_n = 1'b0;
    w = wcnt0;
    @(posedge clk); #1;
    chk("abort_busy", int'(busy0), 0);
    chk("abort_en", int'(en0), 0);
    chk("abort_done", int'(done0), 0);
    chk("abort_addr", int'(addr0), 0);
    chk("abort_oc", int'(oc0), 0);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_writes", wcnt0 - w, 1);
    chk("abort_idle_en", int'(en0), 0);

    w = wcnt0;
    launch(0, 0, 'h10, 8, 'h70, 1);
    @(posedge clk); #1;
    start0 = 1'b1;
    mode = 1'b1; src = 8'h20; len = 8'd6; dest = 8'h78;
    @(posedge clk); #1;
    start0 = 1'b0;
    wait_done();
    chk("busy_start_r70", int'(ram0['h70]), 1);
    chk("busy_start_r71", int'(ram0['h71]), 5);
    chk("busy_start_wcnt", wcnt0 - w, 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
